// File: rtl/branch_predictor_pkg.sv
// rtl/branch_predictor_pkg.sv - branch type codes, compare codes and BHT defaults
package branch_predictor_pkg;

  typedef enum logic [1:0] {
    NOTBRANCH    = 2'b00,
    UNCONDBRANCH = 2'b01,
    CONDBRANCH   = 2'b10,
    BRANCH_RSVD  = 2'b11
  } branch_flag_e;

  // sign_bits value meaning the ALU compare condition is true
  localparam logic [1:0] SIGN_ZERO = 2'b00;

  // weakly not-taken reset value for every BHT counter
  localparam int BHT_WEAK_NT = 1;

  function automatic logic resolve_taken(logic [1:0] branch_flag, logic [1:0] sign_bits);
    logic taken;
    taken = 1'b0;
    case (branch_flag)
      UNCONDBRANCH: taken = 1'b1;
      CONDBRANCH:   taken = (sign_bits == SIGN_ZERO);
      default:      taken = 1'b0;
    endcase
    return taken;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// rtl/branch_predictor_if.sv - fetch predict port and execute resolve port
// BRANCH_STAT_EN adds the statistics counters to the bundle.
interface branch_predictor_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] pred_pc;
  logic                  pred_taken;
  logic                  res_valid;
  logic [ADDR_WIDTH-1:0] res_pc;
  logic [1:0]            branch_flag;
  logic [1:0]            sign_bits;
  logic                  res_pred_taken;
  logic                  special_pc_flag;
  logic                  mispredict;
`ifdef BRANCH_STAT_EN
  logic [31:0]           stat_branches;
  logic [31:0]           stat_mispredicts;
`endif

  modport master (
    output pred_pc, res_valid, res_pc, branch_flag, sign_bits, res_pred_taken,
    input  pred_taken, special_pc_flag, mispredict
`ifdef BRANCH_STAT_EN
    , input stat_branches, stat_mispredicts
`endif
  );

  modport slave (
    input  pred_pc, res_valid, res_pc, branch_flag, sign_bits, res_pred_taken,
    output pred_taken, special_pc_flag, mispredict
`ifdef BRANCH_STAT_EN
    , output stat_branches, stat_mispredicts
`endif
  );

endinterface

// File: rtl/branch_predictor_sat_counter.sv
// rtl/branch_predictor_sat_counter.sv - saturating up/down next-value for a BHT counter
module sat_counter #(
  parameter int CNT_WIDTH = 2
) (
  input  logic [CNT_WIDTH-1:0] cnt,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] nxt
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  always_comb begin
    nxt = cnt;
    if (inc) begin
      if (cnt != CNT_MAX) nxt = cnt + CNT_ONE;
    end else begin
      if (cnt != '0) nxt = cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - PC-indexed BHT predictor with registered redirect on resolve
// Optional statistics counters are compiled in with BRANCH_STAT_EN.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IDX_WIDTH  = 6,
  parameter int CNT_WIDTH  = 2,
  parameter int CNT_INIT   = BHT_WEAK_NT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rdy_in,
  branch_predictor_if.slave  bus
);

  localparam int DEPTH = 1 << IDX_WIDTH;
  localparam logic [CNT_WIDTH-1:0] INIT_VAL = CNT_WIDTH'(CNT_INIT);

  logic [CNT_WIDTH-1:0]  bht [DEPTH];
  logic [ADDR_WIDTH-1:0] pred_pc_w;
  logic [ADDR_WIDTH-1:0] res_pc_w;
  logic [IDX_WIDTH-1:0]  pred_idx;
  logic [IDX_WIDTH-1:0]  res_idx;
  logic [CNT_WIDTH-1:0]  cnt_next;
  logic                  actual;
  logic                  is_cond;
  logic                  resolve;
  logic                  wrong;
  logic                  special_q;
  logic                  mispredict_q;
  logic                  unused_pc_bits;

  assign pred_pc_w      = bus.pred_pc;
  assign res_pc_w       = bus.res_pc;
  assign pred_idx       = pred_pc_w[IDX_WIDTH+1:2];
  assign res_idx        = res_pc_w[IDX_WIDTH+1:2];
  // no tag check: only the index bits matter, aliasing PCs share a counter
  assign unused_pc_bits = ^{pred_pc_w, res_pc_w};

  assign actual  = resolve_taken(bus.branch_flag, bus.sign_bits);
  assign is_cond = (bus.branch_flag == CONDBRANCH);
  assign resolve = rdy_in && bus.res_valid;
  assign wrong   = (actual != bus.res_pred_taken);

  // read is the pre-update value; a same-cycle write shows up next cycle
  assign bus.pred_taken = bht[pred_idx][CNT_WIDTH-1];

  sat_counter #(
    .CNT_WIDTH (CNT_WIDTH)
  ) u_sat_counter (
    .cnt (bht[res_idx]),
    .inc (actual),
    .nxt (cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) bht[i] <= INIT_VAL;
      special_q    <= 1'b0;
      mispredict_q <= 1'b0;
    end else if (rdy_in) begin
      if (bus.res_valid) begin
        special_q    <= actual;
        mispredict_q <= wrong;
        if (is_cond) bht[res_idx] <= cnt_next;
      end else begin
        special_q    <= 1'b0;
        mispredict_q <= 1'b0;
      end
    end
  end

  assign bus.special_pc_flag = special_q;
  assign bus.mispredict      = mispredict_q;

`ifdef BRANCH_STAT_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_mp_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else if (resolve) begin
      if (is_cond && stat_br_q != 32'hFFFF_FFFF) stat_br_q <= stat_br_q + 32'd1;
      if (wrong && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bus.stat_branches    = stat_br_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  logic unused_resolve;
  assign unused_resolve = resolve;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - directed plan plus randomized traffic against a counter-array model
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic rdy_in;

  always #5 clk = ~clk;

  branch_predictor_if #(.ADDR_WIDTH(32)) bus ();

  branch_predictor dut (
    .clk    (clk),
    .rst    (rst),
    .rdy_in (rdy_in),
    .bus    (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  int          m_cnt [64];
  logic        m_special;
  logic        m_misp;
  int unsigned m_br;
  int unsigned m_mp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_cnt[i] = 1;
    m_special = 1'b0;
    m_misp    = 1'b0;
    m_br      = 0;
    m_mp      = 0;
  endtask

  // drives one cycle starting just after a rising edge, ends just after the next one
  task automatic cycle(input logic r, input logic rdy, input logic v, input logic [31:0] rpc,
                       input logic [1:0] bf, input logic [1:0] sb, input logic rpt,
                       input logic [31:0] ppc);
    logic act;
    rst                = r;
    rdy_in             = rdy;
    bus.res_valid      = v;
    bus.res_pc         = rpc;
    bus.branch_flag    = bf;
    bus.sign_bits      = sb;
    bus.res_pred_taken = rpt;
    bus.pred_pc        = ppc;
    if (bf == 2'b01)      act = 1'b1;
    else if (bf == 2'b10) act = (sb == SIGN_ZERO);
    else                  act = 1'b0;
    @(negedge clk);
    check("pred_taken", 32'(bus.pred_taken), 32'(m_cnt[idx_of(ppc)] >= 2));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else if (rdy) begin
      if (v) begin
        m_special = act;
        m_misp    = (act != rpt);
        if (bf == 2'b10) begin
          m_br = m_br + 1;
          if (act) m_cnt[idx_of(rpc)] = (m_cnt[idx_of(rpc)] == 3) ? 3 : m_cnt[idx_of(rpc)] + 1;
          else     m_cnt[idx_of(rpc)] = (m_cnt[idx_of(rpc)] == 0) ? 0 : m_cnt[idx_of(rpc)] - 1;
        end
        if (act != rpt) m_mp = m_mp + 1;
      end else begin
        m_special = 1'b0;
        m_misp    = 1'b0;
      end
    end
    #1;
    check("special_pc_flag", 32'(bus.special_pc_flag), 32'(m_special));
    check("mispredict", 32'(bus.mispredict), 32'(m_misp));
`ifdef BRANCH_STAT_EN
    check("stat_branches", bus.stat_branches, m_br);
    check("stat_mispredicts", bus.stat_mispredicts, m_mp);
`endif
  endtask

  initial begin
    rst                = 1'b1;
    rdy_in             = 1'b1;
    bus.res_valid      = 1'b0;
    bus.res_pc         = '0;
    bus.branch_flag    = NOTBRANCH;
    bus.sign_bits      = 2'b11;
    bus.res_pred_taken = 1'b0;
    bus.pred_pc        = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // reset state
    cycle(1, 1, 0, 32'h0, NOTBRANCH, 2'b11, 0, 32'h100);
    cycle(0, 1, 0, 32'h0, NOTBRANCH, 2'b11, 0, 32'h100);
    check("tp_reset_pred", 32'(bus.pred_taken), 32'd0);
    check("tp_reset_misp", 32'(bus.mispredict), 32'd0);

    // two taken resolves climb to strongly taken
    repeat (2) begin
      cycle(0, 1, 1, 32'h100, CONDBRANCH, SIGN_ZERO, 0, 32'h100);
      check("tp_taken_misp", 32'(bus.mispredict), 32'd1);
    end
    cycle(0, 1, 0, 32'h0, NOTBRANCH, 2'b11, 0, 32'h100);
    check("tp_cnt3", 32'(bus.pred_taken), 32'd1);

    // saturate high, then walk down
    repeat (5) cycle(0, 1, 1, 32'h100, CONDBRANCH, SIGN_ZERO, 1, 32'h100);
    check("tp_sat_hi", 32'(bus.pred_taken), 32'd1);
    cycle(0, 1, 1, 32'h100, CONDBRANCH, 2'b01, 1, 32'h100);
    check("tp_cnt2", 32'(bus.pred_taken), 32'd1);
    cycle(0, 1, 1, 32'h100, CONDBRANCH, 2'b10, 1, 32'h100);
    check("tp_cnt1", 32'(bus.pred_taken), 32'd0);

    // unconditional: redirect but no BHT update
    cycle(0, 1, 1, 32'h300, UNCONDBRANCH, 2'b11, 0, 32'h300);
    check("tp_uncond_special", 32'(bus.special_pc_flag), 32'd1);
    check("tp_uncond_misp", 32'(bus.mispredict), 32'd1);
    check("tp_uncond_bht", 32'(bus.pred_taken), 32'd0);

    // stall holds the pulse; reset clears it even while stalled
    repeat (3) begin
      cycle(0, 0, 1, 32'h100, CONDBRANCH, 2'b01, 1, 32'h100);
      check("tp_stall_misp", 32'(bus.mispredict), 32'd1);
    end
    cycle(1, 0, 0, 32'h0, NOTBRANCH, 2'b11, 0, 32'h100);
    check("tp_rst_stall_misp", 32'(bus.mispredict), 32'd0);

    // same-cycle read and write of one entry
    cycle(0, 1, 1, 32'h200, CONDBRANCH, SIGN_ZERO, 0, 32'h200);
    check("tp_same_next", 32'(bus.pred_taken), 32'd1);
`ifdef BRANCH_STAT_EN
    check("tp_same_stat", bus.stat_branches, 32'd1);
`endif

    // reserved code is a non-branch that never touches the BHT
    cycle(0, 1, 1, 32'h200, BRANCH_RSVD, SIGN_ZERO, 1, 32'h200);
    check("tp_rsvd_misp", 32'(bus.mispredict), 32'd1);

    // randomized traffic with aliasing PCs and occasional stalls/resets
    for (int n = 0; n < 600; n++) begin
      logic [31:0] rpc;
      logic [31:0] ppc;
      rpc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
      ppc = (32'($urandom_range(0, 7)) << 2) | (32'($urandom_range(0, 3)) << 8);
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) != 0), rpc, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ppc);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
